// File: rtl/snake_step_controller.sv
// Snake game step sequencer: owns the single-port grid RAM, clears and seeds the field,
// moves head/tail once per tick, places food, and lends the port to VGA while idle.
// state      | meaning
// CLEAR      | row-major wipe, WALL on border, EMPTY inside
// SEED       | write initial head/tail cell at START
// FOOD_RD    | read candidate food cell
// FOOD_CHK   | place food if EMPTY, else request a new candidate
// IDLE       | wait for Tick, VGA owns the port
// OLDHEAD_WR | rewrite old head with the committed direction
// HEAD_RD    | read the cell the head moves into
// HEAD_CHK   | collision / food decision
// HEAD_WR    | write new head
// TAIL_RD    | read tail to learn its direction
// TAIL_WR    | erase tail and advance it
// OVER       | game over, VGA owns the port
module snake_step_controller #(
  parameter int GRID_WIDTH  = 40,
  parameter int GRID_HEIGHT = 30,
  parameter int X_BITS      = 6,
  parameter int Y_BITS      = 5,
  parameter int START_X     = 20,
  parameter int START_Y     = 20
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Tick,
  input  logic                     DirUp,
  input  logic                     DirDown,
  input  logic                     DirLeft,
  input  logic                     DirRight,
  input  logic                     Restart,
  input  logic [X_BITS-1:0]        FoodX,
  input  logic [Y_BITS-1:0]        FoodY,
  output logic                     FoodReq,
  output logic [Y_BITS+X_BITS-1:0] MemAddr,
  output logic                     MemWe,
  output logic [3:0]               MemWData,
  input  logic [3:0]               MemRData,
  input  logic                     VgaReq,
  input  logic [Y_BITS+X_BITS-1:0] VgaAddr,
  output logic                     VgaGnt,
  output logic [1:0]               VgaData,
  output logic [7:0]               Score,
  output logic                     GameOver,
  output logic                     Busy
);

  localparam logic [1:0] BLK_EMPTY = 2'd0;
  localparam logic [1:0] BLK_WALL  = 2'd1;
  localparam logic [1:0] BLK_SNAKE = 2'd2;
  localparam logic [1:0] BLK_FOOD  = 2'd3;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_DOWN  = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam logic [X_BITS-1:0] LAST_COL = X_BITS'(GRID_WIDTH - 1);
  localparam logic [Y_BITS-1:0] LAST_ROW = Y_BITS'(GRID_HEIGHT - 1);
  localparam logic [X_BITS-1:0] START_COL = X_BITS'(START_X);
  localparam logic [Y_BITS-1:0] START_ROW = Y_BITS'(START_Y);

  typedef enum logic [3:0] {
    stClear, stSeed, stFoodRd, stFoodChk, stIdle, stOldHeadWr,
    stHeadRd, stHeadChk, stHeadWr, stTailRd, stTailWr, stOver
  } stateT;

  stateT state, stateNext;

  logic [X_BITS-1:0] clrX, headX, tailX, nextX;
  logic [Y_BITS-1:0] clrY, headY, tailY, nextY;
  logic [1:0] curDir, pendingDir, commitDir;
  logic grow;
  logic [Y_BITS+X_BITS-1:0] foodAddr;
  logic isBorder, clearLast;

  function automatic logic [X_BITS-1:0] stepX(input logic [X_BITS-1:0] x, input logic [1:0] dir);
    logic [X_BITS-1:0] r;
    r = x;
    if (dir == DIR_RIGHT)
      r = (x == LAST_COL) ? '0 : x + X_BITS'(1);
    else if (dir == DIR_LEFT)
      r = (x == '0) ? LAST_COL : x - X_BITS'(1);
    return r;
  endfunction

  function automatic logic [Y_BITS-1:0] stepY(input logic [Y_BITS-1:0] y, input logic [1:0] dir);
    logic [Y_BITS-1:0] r;
    r = y;
    if (dir == DIR_DOWN)
      r = (y == LAST_ROW) ? '0 : y + Y_BITS'(1);
    else if (dir == DIR_UP)
      r = (y == '0) ? LAST_ROW : y - Y_BITS'(1);
    return r;
  endfunction

  // Opposite directions differ only in bit 0, so a reversal is pendingDir == curDir ^ 1.
  assign commitDir = (pendingDir == (curDir ^ 2'b01)) ? curDir : pendingDir;
  assign isBorder  = (clrY == '0) || (clrY == LAST_ROW) || (clrX == '0) || (clrX == LAST_COL);
  assign clearLast = (clrX == LAST_COL) && (clrY == LAST_ROW);

  assign GameOver = (state == stOver);
  assign Busy     = !((state == stIdle) || (state == stOver));
  assign VgaData  = MemRData[1:0];

  always_comb begin
    stateNext = state;
    MemAddr   = {headY, headX};
    MemWe     = 1'b0;
    MemWData  = 4'd0;
    FoodReq   = 1'b0;
    VgaGnt    = 1'b0;
    case (state)
      stClear: begin
        MemAddr  = {clrY, clrX};
        MemWe    = 1'b1;
        MemWData = isBorder ? {2'b00, BLK_WALL} : {2'b00, BLK_EMPTY};
        if (clearLast) stateNext = stSeed;
      end
      stSeed: begin
        MemAddr   = {START_ROW, START_COL};
        MemWe     = 1'b1;
        MemWData  = {DIR_RIGHT, BLK_SNAKE};
        stateNext = stFoodRd;
      end
      stFoodRd: begin
        MemAddr   = {FoodY, FoodX};
        stateNext = stFoodChk;
      end
      stFoodChk: begin
        MemAddr = foodAddr;
        if (MemRData[1:0] == BLK_EMPTY) begin
          MemWe     = 1'b1;
          MemWData  = {2'b00, BLK_FOOD};
          stateNext = stIdle;
        end else begin
          FoodReq   = 1'b1;
          stateNext = stFoodRd;
        end
      end
      stIdle: begin
        VgaGnt = VgaReq;
        if (VgaReq) MemAddr = VgaAddr;
        if (Tick) stateNext = stOldHeadWr;
      end
      stOldHeadWr: begin
        MemWe     = 1'b1;
        MemWData  = {curDir, BLK_SNAKE};
        stateNext = stHeadRd;
      end
      stHeadRd: begin
        MemAddr   = {nextY, nextX};
        stateNext = stHeadChk;
      end
      stHeadChk: begin
        MemAddr = {nextY, nextX};
        if ((MemRData[1:0] == BLK_WALL) || (MemRData[1:0] == BLK_SNAKE))
          stateNext = stOver;
        else
          stateNext = stHeadWr;
      end
      stHeadWr: begin
        MemAddr  = {nextY, nextX};
        MemWe    = 1'b1;
        MemWData = {curDir, BLK_SNAKE};
        if (grow) begin
          FoodReq   = 1'b1;
          stateNext = stFoodRd;
        end else begin
          stateNext = stTailRd;
        end
      end
      stTailRd: begin
        MemAddr   = {tailY, tailX};
        stateNext = stTailWr;
      end
      stTailWr: begin
        MemAddr   = {tailY, tailX};
        MemWe     = 1'b1;
        MemWData  = {2'b00, BLK_EMPTY};
        stateNext = stIdle;
      end
      stOver: begin
        VgaGnt = VgaReq;
        if (VgaReq) MemAddr = VgaAddr;
      end
      default: stateNext = stClear;
    endcase
    // Restart aborts whatever is in flight without committing its write.
    if (Restart) begin
      stateNext = stClear;
      MemWe     = 1'b0;
      FoodReq   = 1'b0;
    end
    if (Reset) begin
      MemWe    = 1'b0;
      MemAddr  = '0;
      MemWData = 4'd0;
      FoodReq  = 1'b0;
      VgaGnt   = 1'b0;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state    <= stClear;
      clrX     <= '0;
      clrY     <= '0;
      headX    <= START_COL;
      headY    <= START_ROW;
      tailX    <= START_COL;
      tailY    <= START_ROW;
      nextX    <= START_COL;
      nextY    <= START_ROW;
      curDir   <= DIR_RIGHT;
      grow     <= 1'b0;
      Score    <= 8'd0;
      foodAddr <= '0;
    end else begin
      state <= stateNext;
      if (Restart) begin
        clrX  <= '0;
        clrY  <= '0;
        Score <= 8'd0;
        grow  <= 1'b0;
      end else begin
        case (state)
          stClear: begin
            if (clrX == LAST_COL) begin
              clrX <= '0;
              clrY <= (clrY == LAST_ROW) ? '0 : clrY + Y_BITS'(1);
            end else begin
              clrX <= clrX + X_BITS'(1);
            end
          end
          stSeed: begin
            headX  <= START_COL;
            headY  <= START_ROW;
            tailX  <= START_COL;
            tailY  <= START_ROW;
            curDir <= DIR_RIGHT;
          end
          stFoodRd: foodAddr <= {FoodY, FoodX};
          stIdle: begin
            if (Tick) begin
              curDir <= commitDir;
              nextX  <= stepX(headX, commitDir);
              nextY  <= stepY(headY, commitDir);
            end
          end
          stHeadChk: begin
            grow <= (MemRData[1:0] == BLK_FOOD);
            if ((MemRData[1:0] == BLK_FOOD) && (Score != 8'hFF))
              Score <= Score + 8'd1;
          end
          stHeadWr: begin
            headX <= nextX;
            headY <= nextY;
          end
          stTailWr: begin
            tailX <= stepX(tailX, MemRData[3:2]);
            tailY <= stepY(tailY, MemRData[3:2]);
          end
          default: ;
        endcase
      end
    end
  end

  // A button pulse in the same cycle as SEED wins over the default heading.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                 pendingDir <= DIR_RIGHT;
    else if (Restart)          pendingDir <= DIR_RIGHT;
    else if (DirUp)            pendingDir <= DIR_UP;
    else if (DirDown)          pendingDir <= DIR_DOWN;
    else if (DirLeft)          pendingDir <= DIR_LEFT;
    else if (DirRight)         pendingDir <= DIR_RIGHT;
    else if (state == stSeed)  pendingDir <= DIR_RIGHT;
  end

endmodule

// File: tb/tb_snake_step_controller.sv
// Directed bench for snake_step_controller: a RAM model, a food-candidate list, and a
// scoreboard of expected RAM writes checked by a separate write monitor.
module tb_snake_step_controller;

  logic Clock = 1'b0;
  logic Reset, Tick, DirUp, DirDown, DirLeft, DirRight, Restart;
  logic [5:0] FoodX;
  logic [4:0] FoodY;
  logic FoodReq;
  logic [10:0] MemAddr;
  logic MemWe;
  logic [3:0] MemWData;
  logic [3:0] MemRData;
  logic VgaReq;
  logic [10:0] VgaAddr;
  logic VgaGnt;
  logic [1:0] VgaData;
  logic [7:0] Score;
  logic GameOver, Busy;

  snake_step_controller dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick),
    .DirUp(DirUp), .DirDown(DirDown), .DirLeft(DirLeft), .DirRight(DirRight),
    .Restart(Restart), .FoodX(FoodX), .FoodY(FoodY), .FoodReq(FoodReq),
    .MemAddr(MemAddr), .MemWe(MemWe), .MemWData(MemWData), .MemRData(MemRData),
    .VgaReq(VgaReq), .VgaAddr(VgaAddr), .VgaGnt(VgaGnt), .VgaData(VgaData),
    .Score(Score), .GameOver(GameOver), .Busy(Busy)
  );

  initial forever #5 Clock = ~Clock;

  logic [3:0] ram [0:2047];
  always @(posedge Clock) begin
    if (MemWe) ram[MemAddr] <= MemWData;
    MemRData <= ram[MemAddr];
  end

  int total = 0;
  int bad = 0;
  int writesSeen = 0;
  int foodReqs = 0;
  logic [14:0] expQ[$];

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic pushWr(input int row, input int col, input logic [3:0] d);
    logic [4:0] r;
    logic [5:0] c;
    r = row[4:0];
    c = col[5:0];
    expQ.push_back({r, c, d});
  endtask

  task automatic pushClear();
    for (int r = 0; r < 30; r++)
      for (int c = 0; c < 40; c++)
        pushWr(r, c, (r == 0 || r == 29 || c == 0 || c == 39) ? 4'h1 : 4'h0);
  endtask

  task automatic nxt();
    @(negedge Clock);
    #1;
  endtask

  task automatic waitIdle(input int start, input int req, input string name);
    int n;
    n = start;
    while (Busy && n < 5000) begin
      nxt();
      n++;
    end
    chk(name, n, req);
  endtask

  task automatic tickStep(input int req, input string name);
    Tick = 1'b1;
    nxt();
    Tick = 1'b0;
    waitIdle(1, req, name);
  endtask

  // Write monitor: every RAM write must match the head of the expected queue.
  initial begin
    logic [14:0] e;
    forever begin
      @(negedge Clock);
      #3;
      if (MemWe === 1'b1) begin
        writesSeen++;
        total++;
        if (expQ.size() == 0) begin
          bad++;
          $display("FAIL wr_unexpected got addr=%03h data=%h required no write", MemAddr, MemWData);
        end else begin
          e = expQ.pop_front();
          if ({MemAddr, MemWData} !== e) begin
            bad++;
            $display("FAIL wr_%0d got row=%0d col=%0d data=%h required row=%0d col=%0d data=%h",
                     writesSeen, MemAddr[10:6], MemAddr[5:0], MemWData, e[14:10], e[9:4], e[3:0]);
          end
        end
      end
    end
  end

  // Food generator: advance on FoodReq and after each successful placement.
  int foodRow[10] = '{20, 0, 5, 20, 1, 20, 20, 7, 3, 2};
  int foodCol[10] = '{20, 5, 5, 21, 1, 20, 21, 9, 3, 2};
  int fIdx = 0;
  initial begin
    FoodY = 5'(foodRow[0]);
    FoodX = 6'(foodCol[0]);
    forever begin
      @(negedge Clock);
      #3;
      if (FoodReq === 1'b1 || (MemWe === 1'b1 && MemWData === 4'h3)) begin
        if (FoodReq === 1'b1) foodReqs++;
        if (fIdx < 9) fIdx++;
        FoodY = 5'(foodRow[fIdx]);
        FoodX = 6'(foodCol[fIdx]);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int frq, ws;
    Reset = 1'b1; Tick = 1'b0; Restart = 1'b0;
    DirUp = 1'b0; DirDown = 1'b0; DirLeft = 1'b0; DirRight = 1'b0;
    VgaReq = 1'b1;
    VgaAddr = {5'd20, 6'd21};
    repeat (3) nxt();
    chk("rst_we", MemWe, 0);
    chk("rst_addr", MemAddr, 0);
    chk("rst_wdata", MemWData, 0);
    chk("rst_gnt", VgaGnt, 0);
    chk("rst_foodreq", FoodReq, 0);
    chk("rst_score", Score, 0);
    chk("rst_over", GameOver, 0);
    chk("rst_busy", Busy, 1);

    // Power-up: clear, seed, food retries at snake (20,20) and wall (0,5), placed at (5,5).
    pushClear();
    pushWr(20, 20, 4'hE);
    pushWr(5, 5, 4'h3);
    frq = foodReqs;
    Reset = 1'b0;
    waitIdle(0, 1207, "init_cycles");
    chk("init_foodreqs", foodReqs - frq, 2);
    chk("init_q_left", expQ.size(), 0);

    // Plain step with VGA holding the request the whole time.
    chk("vga_gnt_pre", VgaGnt, 1);
    nxt();
    chk("vga_data_pre", VgaData, 0);
    pushWr(20, 20, 4'hE);
    pushWr(20, 21, 4'hE);
    pushWr(20, 20, 4'h0);
    Tick = 1'b1;
    nxt();
    Tick = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      chk("vga_gnt_step", VgaGnt, 0);
      nxt();
    end
    chk("step_busy_at7", Busy, 0);
    chk("vga_gnt_post", VgaGnt, 1);
    nxt();
    chk("vga_data_post", VgaData, 2);

    // Reversal (LEFT while heading RIGHT) is ignored; then turn UP.
    DirLeft = 1'b1;
    nxt();
    DirLeft = 1'b0;
    pushWr(20, 21, 4'hE);
    pushWr(20, 22, 4'hE);
    pushWr(20, 21, 4'h0);
    tickStep(7, "reverse_cycles");
    DirUp = 1'b1;
    nxt();
    DirUp = 1'b0;
    pushWr(20, 22, 4'h2);
    pushWr(19, 22, 4'h2);
    pushWr(20, 22, 4'h0);
    tickStep(7, "up_cycles");
    chk("turn_q_left", expQ.size(), 0);

    // Restart mid-step: pending UP must be discarded, OLDHEAD write suppressed.
    Tick = 1'b1;
    nxt();
    Tick = 1'b0;
    Restart = 1'b1;
    #1;
    chk("restart_abort_we", MemWe, 0);
    pushClear();
    pushWr(20, 20, 4'hE);
    pushWr(20, 21, 4'h3);
    nxt();
    Restart = 1'b0;
    chk("restart_score", Score, 0);
    Tick = 1'b1;
    nxt();
    Tick = 1'b0;
    waitIdle(1, 1203, "restart_cycles");
    for (int k = 0; k < 3; k++) begin
      nxt();
      chk("tick_dropped", Busy, 0);
    end

    // Eat food at (20,21); refill retries (20,20), (20,21), places at (7,9).
    pushWr(20, 20, 4'hE);
    pushWr(20, 21, 4'hE);
    pushWr(7, 9, 4'h3);
    frq = foodReqs;
    tickStep(11, "grow_cycles");
    chk("grow_score", Score, 1);
    chk("grow_foodreqs", foodReqs - frq, 3);

    // Length-2 snake runs right into the border at column 39.
    for (int h = 21; h <= 37; h++) begin
      pushWr(20, h, 4'hE);
      pushWr(20, h + 1, 4'hE);
      pushWr(20, h - 1, 4'h0);
      tickStep(7, "run_cycles");
    end
    pushWr(20, 38, 4'hE);
    tickStep(4, "wall_cycles");
    chk("wall_over", GameOver, 1);
    chk("wall_score", Score, 1);

    ws = writesSeen;
    for (int k = 0; k < 3; k++) begin
      Tick = 1'b1;
      nxt();
      Tick = 1'b0;
      nxt();
    end
    chk("over_writes", writesSeen - ws, 0);
    chk("over_stays", GameOver, 1);
    VgaReq = 1'b0;
    #1;
    chk("over_gnt_lo", VgaGnt, 0);
    VgaAddr = {5'd20, 6'd39};
    VgaReq = 1'b1;
    #1;
    chk("over_gnt_hi", VgaGnt, 1);
    nxt();
    chk("over_vga_wall", VgaData, 1);
    VgaAddr = {5'd20, 6'd38};
    nxt();
    chk("over_vga_snake", VgaData, 2);

    // Restart from OVER: full re-clear, food lands at (3,3).
    pushClear();
    pushWr(20, 20, 4'hE);
    pushWr(3, 3, 4'h3);
    Restart = 1'b1;
    nxt();
    Restart = 1'b0;
    chk("restart2_over", GameOver, 0);
    chk("restart2_score", Score, 0);
    waitIdle(0, 1203, "restart2_cycles");
    nxt();
    chk("final_q_left", expQ.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
